alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, registered successor to the combinational datapath ALU. It adds an iterative unsigned multiplier and divider that produce double-width results, and a start/busy/done handshake so the MIPS control unit can stall on long operations. It sits in the execute stage. Single-cycle operations return on the cycle after start; multiply and divide occupy the unit for WIDTH cycles.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  operation request; sampled on rising clk edge
- a  in  WIDTH  operand A; captured at accepted start
- b  in  WIDTH  operand B; captured at accepted start
- sel  in  3  operation select; captured at accepted start
- res  out  WIDTH  primary result (low word, sum, logic result, quotient)
- hi  out  WIDTH  secondary result (product high word, remainder; 0 for other ops)
- ZF  out  1  1 when res == 0 after the last completed operation
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse; res/hi/ZF just updated

## Operation
- sel encoding, all arithmetic modulo 2^WIDTH and unsigned:
  - 000 add: res = a+b
  - 001 sub: res = a-b
  - 010 or
  - 011 and
  - 100 sltu: res = {0…,a<b}
  - 101 xor
  - 110 divu: res = a/b, hi = a%b
  - 111 mulu: {hi,res} = a*b, full 2·WIDTH product
- For single-cycle ops (000–101), hi is written 0.
- FSM states: IDLE, MUL, DIV.
- IDLE + start + single-cycle sel: res/hi/ZF registered at that edge, done=1 next cycle, stay IDLE.
- IDLE + start + sel 111: latch operands, clear accumulator, go to MUL with counter=0.
  - One shift-add step per cycle, LSB of multiplier first.
- IDLE + start + sel 110: latch operands, go to DIV.
  - Restoring division, one quotient bit per cycle, MSB first.
- MUL/DIV: counter increments each cycle. At the edge where counter reaches WIDTH-1:
  - write res/hi/ZF
  - return to IDLE
  - done=1 and busy=0 in the following cycle
- start while busy=1 is ignored: no latch, no queue. The caller must hold or reissue it.
- Divide by zero runs the normal WIDTH iterations and yields res = all-ones, hi = a. No error flag.
- res, hi and ZF hold their values between completions. They are never driven with partial results.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counter=0, res=0, hi=0, ZF=1, busy=0, done=0. Operand latches are cleared.
- Reset mid-MUL/DIV aborts the operation. No done pulse follows.
- Cycle numbering: start accepted at edge E0.
  - Single-cycle op: done=1 during cycle E0→E1.
  - mul/div: busy=1 during cycles E0→E1 … E(WIDTH-1)→E(WIDTH); done=1, busy=0 during E(WIDTH)→E(WIDTH+1).
  - Total latency = WIDTH+1 edges to done.
- done is high for exactly one cycle per accepted start.
- A start in the done cycle is accepted, giving back-to-back operation. For a single-cycle op, done stays high one more cycle with the new result.
- busy and done are never both 1.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Configuration
- ALU_DIV_EN defined: divider datapath and DIV state are compiled in; sel 110 behaves as specified above.
- ALU_DIV_EN undefined: divider logic is removed. sel 110 is treated as a single-cycle op:
  - res = 0, hi = 0, ZF = 1, done on the next cycle, busy never asserted.
  - All other ops are unchanged.

## Test plan
- Reset, then add a=32'hFFFFFFFF, b=1 -> done one cycle later, res=0, ZF=1, hi=0; sltu a=3, b=5 -> res=1, ZF=0.
- mulu a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy high exactly 32 cycles, then done pulse with hi=32'hFFFFFFFE, res=32'h00000001, ZF=0.
- divu a=100, b=7 -> res=14, hi=2 after 33 edges; divu a=5, b=0 -> res=32'hFFFFFFFF, hi=5. With ALU_DIV_EN undefined: res=0, hi=0, done in 1 cycle.
- start with or a=1, b=2 pulsed mid-multiply -> ignored. Multiply result is unchanged, exactly one done pulse, res does not become 3.
- rst asserted at cycle 10 of mulu 7×9 -> outputs zero immediately, ZF=1, busy=0, no done; next mulu 7×9 -> res=63, hi=0.
- Back-to-back: start sub 10-3 in the done cycle of a mulu -> next cycle done=1, res=7, hi=0.

Source files
------------

// File: rtl/alu_mdu.sv
// Registered execute-stage ALU with iterative unsigned multiply/divide and a start/busy/done handshake.
// Define ALU_DIV_EN to compile in the restoring divider; otherwise divu returns zero in one cycle.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] hi,
    output logic             ZF,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zf_q, zf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_p;

    always_comb begin
        alu_res = '0;
        case (sel)
            3'b000:  alu_res = a + b;
            3'b001:  alu_res = a - b;
            3'b010:  alu_res = a | b;
            3'b011:  alu_res = a & b;
            3'b100:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            3'b101:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    // Multiply: {acc, opa} is the product register; multiplier shifts out of opa LSB first.
    assign mul_sum = {1'b0, acc_q} + (opa_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign mul_p   = {mul_sum, opa_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    // Divide: acc is the partial remainder, opa shifts dividend bits out MSB first and quotient bits in.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    assign div_shift = {acc_q, opa_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
    assign div_quo   = {opa_q[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        hi_d    = hi_q;
        zf_d    = zf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (sel)
                        3'b111: begin
                            opa_d   = a;
                            opb_d   = b;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = MUL;
                        end
`ifdef ALU_DIV_EN
                        3'b110: begin
                            opa_d   = a;
                            opb_d   = b;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = DIV;
                        end
`endif
                        default: begin
                            res_d  = alu_res;
                            hi_d   = '0;
                            zf_d   = (alu_res == '0);
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = mul_p[2*WIDTH-1:WIDTH];
                opa_d = mul_p[WIDTH-1:0];
                if (cnt_q == LAST) begin
                    res_d   = mul_p[WIDTH-1:0];
                    hi_d    = mul_p[2*WIDTH-1:WIDTH];
                    zf_d    = (mul_p[WIDTH-1:0] == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
`ifdef ALU_DIV_EN
            DIV: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = div_rem;
                opa_d = div_quo;
                if (cnt_q == LAST) begin
                    res_d   = div_quo;
                    hi_d    = div_rem;
                    zf_d    = (div_quo == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            zf_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zf_q    <= zf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign res  = res_q;
    assign hi   = hi_q;
    assign ZF   = zf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: stimulus pushes expected results, a negedge monitor pops on done.
// Divide expectations follow ALU_DIV_EN.
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [2:0]   sel;
    logic [W-1:0] res, hi;
    logic         ZF, busy, done;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sel(sel),
        .res(res), .hi(hi), .ZF(ZF), .busy(busy), .done(done)
    );

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] h;
        logic         z;
        int           due;
        int           id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   next_id = 0;

`ifdef ALU_DIV_EN
    localparam int DIV_LAT = W;
    localparam bit DIV_ON  = 1'b1;
`else
    localparam int DIV_LAT = 0;
    localparam bit DIV_ON  = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation, on its due cycle.
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b required busy=0 cyc=%0d", busy, done, cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: res=%h hi=%h ZF=%0b cyc=%0d, required no done", res, hi, ZF, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (res !== mon_e.r || hi !== mon_e.h || ZF !== mon_e.z || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL txn%0d: res=%h hi=%h ZF=%0b cyc=%0d, required res=%h hi=%h ZF=%0b cyc=%0d",
                             mon_e.id, res, hi, ZF, cyc, mon_e.r, mon_e.h, mon_e.z, mon_e.due);
                end else begin
                    $display("txn%0d: res=%h hi=%h ZF=%0b cyc=%0d", mon_e.id, res, hi, ZF, cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; returns one negedge later with start dropped.
    task automatic issue(input logic [2:0] s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit push, input logic [W-1:0] er, input logic [W-1:0] eh, input int lat);
        exp_t e;
        sel   = s;
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) begin
            e.r   = er;
            e.h   = eh;
            e.z   = (er == '0);
            e.due = cyc + 1 + lat;
            e.id  = next_id;
            next_id++;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d busy=%0b, required pending=0 busy=0", sb.size(), busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sel   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_res",  res, '0);
        chk("rst_hi",   hi,  '0);
        chk("rst_zf",   W'(ZF), W'(1));
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle ops, each issued in the previous op's done cycle.
        issue(3'b000, 32'hFFFF_FFFF, 32'd1, 1, 32'h0, 32'h0, 0);
        issue(3'b100, 32'd3, 32'd5, 1, 32'd1, 32'h0, 0);
        issue(3'b001, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 32'h0, 0);
        issue(3'b010, 32'h0000_00F0, 32'h0000_000F, 1, 32'h0000_00FF, 32'h0, 0);
        issue(3'b011, 32'h0000_FF00, 32'h0000_0F0F, 1, 32'h0000_0F00, 32'h0, 0);
        issue(3'b101, 32'h0000_AAAA, 32'h0000_FFFF, 1, 32'h0000_5555, 32'h0, 0);
        issue(3'b100, 32'd5, 32'd3, 1, 32'd0, 32'h0, 0);
        issue(3'b100, 32'hFFFF_FFFF, 32'd0, 1, 32'd0, 32'h0, 0);
        drain();

        // Full-range multiply, busy length, then back-to-back sub in the done cycle.
        issue(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001, 32'hFFFF_FFFE, W);
        bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            if (busy) bcnt++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", W'(bcnt), W'(32));
        issue(3'b001, 32'd10, 32'd3, 1, 32'd7, 32'h0, 0);
        drain();

        issue(3'b110, 32'd100, 32'd7, 1, DIV_ON ? 32'd14 : 32'd0, DIV_ON ? 32'd2 : 32'd0, DIV_LAT);
        drain();
        issue(3'b110, 32'd5, 32'd0, 1, DIV_ON ? 32'hFFFF_FFFF : 32'd0, DIV_ON ? 32'd5 : 32'd0, DIV_LAT);
        drain();
        issue(3'b110, 32'd7, 32'd100, 1, 32'd0, DIV_ON ? 32'd7 : 32'd0, DIV_LAT);
        drain();
        issue(3'b111, 32'd0, 32'd123, 1, 32'd0, 32'd0, W);
        drain();

        // A start pulsed mid-multiply must be ignored.
        issue(3'b111, 32'd12345, 32'd6789, 1, 32'd83810205, 32'd0, W);
        repeat (5) @(negedge clk);
        issue(3'b010, 32'd1, 32'd2, 0, 32'd0, 32'd0, 0);
        drain();
        repeat (5) @(negedge clk);

        // Reset at cycle 10 of a multiply aborts it with no done.
        issue(3'b111, 32'd7, 32'd9, 0, 32'd0, 32'd0, 0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_res",  res, '0);
        chk("abort_hi",   hi,  '0);
        chk("abort_zf",   W'(ZF), W'(1));
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_idle_busy", W'(busy), '0);
        issue(3'b111, 32'd7, 32'd9, 1, 32'd63, 32'd0, W);
        drain();
        repeat (3) @(negedge clk);

        chk("pending_expectations", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
